// File: rtl/hdc_pkg.sv
`default_nettype none
// ============================================================================
// Module : hdc_pkg
// Purpose: Shared definitions for the HDC spam/ham classifier sequencer:
//          result label codes, sequencer state encoding and default
//          message geometry.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package hdc_pkg;

    // Default message geometry used by the sequencer parameters.
    localparam int HDC_CHAR_LENGTH    = 8;
    localparam int HDC_MESSAGE_LENGTH = 200;

    // Classification result codes.
    localparam logic [1:0] LABEL_HAM     = 2'b00;
    localparam logic [1:0] LABEL_SPAM    = 2'b01;
    localparam logic [1:0] LABEL_ERR     = 2'b10;
    localparam logic [1:0] LABEL_INCONCL = 2'b11;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_THRESH = 3'd3,
        S_CMP    = 3'd4,
        S_DECIDE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage : hdc_pkg
`default_nettype wire

// File: rtl/hdc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : hdc_wait_timer
// Purpose: Watchdog for datapath handshakes. load_i restarts the count,
//          count_i marks a waiting cycle, expired_o flags the TIMEOUT-th
//          consecutive waiting cycle. TIMEOUT = 0 means it never expires.
// Ports  : clk, rst_n (async active-low), load_i, count_i, expired_o
// Rev    : 1.0 - initial release
// ============================================================================
module hdc_wait_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    if (TIMEOUT == 0) begin : g_never
        assign expired_o = 1'b0;
    end else begin : g_count
        localparam int              c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

        logic [c_CNT_W-1:0] cnt_q;
        logic [c_CNT_W-1:0] cnt_d;

        // Expiry is reported during the last allowed waiting cycle so the
        // owner can leave the wait state on that same edge.
        assign expired_o = count_i && (cnt_q == c_LAST);

        always_comb begin
            cnt_d = cnt_q;
            if (load_i) begin
                cnt_d = '0;
            end else if (count_i && !expired_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule : hdc_wait_timer
`default_nettype wire

// File: rtl/hdc_classify_seq.sv
`default_nettype none
// ============================================================================
// Module : hdc_classify_seq
// Purpose: Control sequencer for the hyperdimensional spam/ham classifier.
//          Latches a message, streams its characters into the n-gram
//          encoder, triggers bundle thresholding, then runs Hamming
//          comparisons against the ham and spam class vectors and reports
//          a 2-bit label.
// Ports  : clk, reset (async active-low)
//          start, msg, length                  - message source
//          busy, done, result                  - status / label
//          char_out, char_valid, char_ready,
//          ngram_valid, acc_clear              - encoder/bundler
//          thr_start, thr_done                 - thresholder
//          cmp_start, cmp_class, cmp_done,
//          cmp_dist                            - associative memory
// Rev    : 1.0 - initial release
// ============================================================================
module hdc_classify_seq
    import hdc_pkg::*;
#(
    parameter int MESSAGE_LENGTH = HDC_MESSAGE_LENGTH,
    parameter int CHAR_LENGTH    = HDC_CHAR_LENGTH,
    parameter int NGRAM          = 3,
    parameter int DIM            = 1024,
    parameter int DIST_W         = $clog2(DIM) + 1,
    parameter int TIMEOUT        = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
    input  logic [7:0]                           length,
    output logic                                 busy,
    output logic                                 done,
    output logic [1:0]                           result,
    output logic [CHAR_LENGTH-1:0]               char_out,
    output logic                                 char_valid,
    input  logic                                 char_ready,
    output logic                                 ngram_valid,
    output logic                                 acc_clear,
    output logic                                 thr_start,
    input  logic                                 thr_done,
    output logic                                 cmp_start,
    output logic                                 cmp_class,
    input  logic                                 cmp_done,
    input  logic [DIST_W-1:0]                    cmp_dist
);

    localparam int         c_MSG_W   = CHAR_LENGTH * MESSAGE_LENGTH;
    localparam logic [7:0] c_MAX_LEN = 8'(MESSAGE_LENGTH);
    localparam logic [7:0] c_NGRAM   = 8'(NGRAM);
    localparam logic [7:0] c_NG_LAST = 8'(NGRAM - 1);

    state_t              state_q,  state_d;
    logic [c_MSG_W-1:0]  msg_q,    msg_d;
    logic [7:0]          len_q,    len_d;
    logic [7:0]          idx_q,    idx_d;
    logic                cls_q,    cls_d;
    logic                first_q,  first_d;
    logic [DIST_W-1:0]   dham_q,   dham_d;
    logic [DIST_W-1:0]   dspam_q,  dspam_d;
    logic [1:0]          result_q, result_d;

    logic                tmr_load;
    logic                tmr_count;
    logic                tmr_expired;

    hdc_wait_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (tmr_load),
        .count_i   (tmr_count),
        .expired_o (tmr_expired)
    );

    assign result = result_q;

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cls_d       = cls_q;
        first_d     = 1'b0;
        dham_d      = dham_q;
        dspam_d     = dspam_q;
        result_d    = result_q;
        tmr_load    = 1'b0;
        tmr_count   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        char_out    = '0;
        char_valid  = 1'b0;
        ngram_valid = 1'b0;
        acc_clear   = 1'b0;
        thr_start   = 1'b0;
        cmp_start   = 1'b0;
        cmp_class   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = msg;
                    len_d   = (length > c_MAX_LEN) ? c_MAX_LEN : length;
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
                idx_d     = '0;
                // Too short to form a single n-gram: nothing to classify.
                if (len_q < c_NGRAM) begin
                    result_d = LABEL_INCONCL;
                    state_d  = S_DONE;
                end else begin
                    result_d = LABEL_HAM;
                    state_d  = S_FEED;
                end
            end

            S_FEED: begin
                busy        = 1'b1;
                char_valid  = 1'b1;
                // The latched message shifts up one char per transfer, so
                // the current char is always the top slice.
                char_out    = msg_q[c_MSG_W-1 -: CHAR_LENGTH];
                ngram_valid = (idx_q >= c_NG_LAST);
                if (char_ready) begin
                    msg_d = msg_q << CHAR_LENGTH;
                    idx_d = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) begin
                        state_d  = S_THRESH;
                        first_d  = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end

            S_THRESH: begin
                busy      = 1'b1;
                thr_start = first_q;
                tmr_count = 1'b1;
                // A thr_done coincident with our own pulse is stale.
                if (thr_done && !first_q) begin
                    state_d  = S_CMP;
                    cls_d    = 1'b0;
                    first_d  = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_expired) begin
                    result_d = LABEL_ERR;
                    state_d  = S_DONE;
                end
            end

            S_CMP: begin
                busy      = 1'b1;
                cmp_start = first_q;
                cmp_class = cls_q;
                tmr_count = 1'b1;
                if (cmp_done) begin
                    if (!cls_q) begin
                        dham_d   = cmp_dist;
                        cls_d    = 1'b1;
                        first_d  = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        dspam_d  = cmp_dist;
                        state_d  = S_DECIDE;
                    end
                end else if (tmr_expired) begin
                    result_d = LABEL_ERR;
                    state_d  = S_DONE;
                end
            end

            S_DECIDE: begin
                busy = 1'b1;
                if (dham_q < dspam_q) begin
                    result_d = LABEL_HAM;
                end else if (dspam_q < dham_q) begin
                    result_d = LABEL_SPAM;
                end else begin
                    result_d = LABEL_INCONCL;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            cls_q    <= 1'b0;
            first_q  <= 1'b0;
            dham_q   <= '0;
            dspam_q  <= '0;
            result_q <= LABEL_HAM;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cls_q    <= cls_d;
            first_q  <= first_d;
            dham_q   <= dham_d;
            dspam_q  <= dspam_d;
            result_q <= result_d;
        end
    end

endmodule : hdc_classify_seq
`default_nettype wire

// File: tb/tb_hdc_classify_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_hdc_classify_seq
// Purpose: Self-checking bench for hdc_classify_seq. Models the encoder,
//          thresholder and associative memory handshakes; expected chars,
//          labels and latencies are queued at stimulus time and compared
//          when the DUT produces them.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hdc_classify_seq;

    localparam int ML = 200;
    localparam int CL = 8;
    localparam int NG = 3;
    localparam int DW = 11;
    localparam int TO = 16;
    localparam int MW = ML * CL;

    logic          clk;
    logic          reset;
    logic          start;
    logic [MW-1:0] msg;
    logic [7:0]    length;
    logic          busy;
    logic          done;
    logic [1:0]    result;
    logic [CL-1:0] char_out;
    logic          char_valid;
    logic          char_ready;
    logic          ngram_valid;
    logic          acc_clear;
    logic          thr_start;
    logic          thr_done;
    logic          cmp_start;
    logic          cmp_class;
    logic          cmp_done;
    logic [DW-1:0] cmp_dist;

    hdc_classify_seq #(
        .MESSAGE_LENGTH (ML),
        .CHAR_LENGTH    (CL),
        .NGRAM          (NG),
        .DIM            (1024),
        .DIST_W         (DW),
        .TIMEOUT        (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .msg         (msg),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .ngram_valid (ngram_valid),
        .acc_clear   (acc_clear),
        .thr_start   (thr_start),
        .thr_done    (thr_done),
        .cmp_start   (cmp_start),
        .cmp_class   (cmp_class),
        .cmp_done    (cmp_done),
        .cmp_dist    (cmp_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues.
    logic [7:0] q_char[$];
    bit         q_ngv[$];
    logic [1:0] q_res[$];
    int         q_lat[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_done   = 0;
    longint        t_acc    = 0;
    bit            tog_ready = 1'b0;
    bit            hang_spam = 1'b0;
    logic [DW-1:0] dist_ham  = '0;
    logic [DW-1:0] dist_spam = '0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: transfers happen on the next posedge when valid&ready
    // are seen here, since char_ready only moves just after a posedge.
    always @(negedge clk) begin
        if (reset) begin
            if (char_valid && char_ready) begin
                if (q_char.size() == 0) begin
                    check_eq("extra_xfer", 32'(char_valid), 32'd0);
                end else begin
                    check_eq("char_out", 32'(char_out), 32'(q_char.pop_front()));
                    check_eq("ngram_valid", 32'(ngram_valid), 32'(q_ngv.pop_front()));
                end
            end
            if (done) begin
                n_done++;
                if (q_res.size() == 0) begin
                    check_eq("extra_done", 32'(done), 32'd0);
                end else begin
                    int lat;
                    lat = q_lat.pop_front();
                    check_eq("result", 32'(result), 32'(q_res.pop_front()));
                    check_eq("busy_at_done", 32'(busy), 32'd1);
                    if (lat >= 0) begin
                        check_eq("latency", 32'(($time - t_acc + 5) / 10), 32'(lat));
                    end
                end
            end
        end
    end

    // Thresholder model: done one cycle after the start pulse.
    always @(negedge clk) begin
        if (reset && thr_start) begin
            @(posedge clk);
            #1 thr_done = 1'b1;
            @(posedge clk);
            #1 thr_done = 1'b0;
        end
    end

    // Associative-memory model: distance one cycle after the start pulse;
    // optionally never answers for the spam class.
    always @(negedge clk) begin
        if (reset && cmp_start) begin
            logic c;
            c = cmp_class;
            @(posedge clk);
            #1;
            if (!(c && hang_spam)) begin
                cmp_done = 1'b1;
                cmp_dist = c ? dist_spam : dist_ham;
            end
            @(posedge clk);
            #1 cmp_done = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_ready) char_ready = ~char_ready;
    end

    task automatic run_msg(input int len_in, input int dh, input int ds,
                           input bit tog, input bit hang, input bit poke,
                           input int abort_at);
        logic [MW-1:0] m;
        logic [7:0]    ch;
        logic [1:0]    exp_r;
        int            leff;
        int            d0;
        int            k;

        leff = (len_in > ML) ? ML : len_in;
        m = '0;
        for (int i = 0; i < ML; i++) begin
            ch = 8'($urandom);
            m  = {m[MW-CL-1:0], ch};
            if (i < leff && leff >= NG) begin
                q_char.push_back(ch);
                q_ngv.push_back(i >= NG - 1);
            end
        end
        if (leff < NG) begin
            exp_r = 2'b11;
            q_lat.push_back(2);
        end else if (hang) begin
            exp_r = 2'b10;
            q_lat.push_back(leff + 22);
        end else begin
            exp_r = (dh < ds) ? 2'b00 : ((ds < dh) ? 2'b01 : 2'b11);
            q_lat.push_back(tog ? -1 : leff + 9);
        end
        q_res.push_back(exp_r);

        dist_ham   = DW'(dh);
        dist_spam  = DW'(ds);
        hang_spam  = hang;
        char_ready = 1'b1;
        tog_ready  = tog;
        d0 = n_done;

        @(negedge clk);
        msg    = m;
        length = 8'(len_in);
        start  = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1 start = 1'b0;

        @(negedge clk);
        check_eq("clear_acc", 32'(acc_clear), 32'd1);
        check_eq("clear_busy", 32'(busy), 32'd1);
        @(negedge clk);
        if (leff >= NG) check_eq("result_cleared", 32'(result), 32'd0);

        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            #2 reset = 1'b0;
            #1;
            check_eq("abort_outs", 32'({busy, done, char_valid, ngram_valid, acc_clear,
                                        thr_start, cmp_start, cmp_class, result}), 32'd0);
            check_eq("abort_char", 32'(char_out), 32'd0);
            q_char.delete();
            q_ngv.delete();
            q_res.delete();
            q_lat.delete();
            @(negedge clk);
            reset = 1'b1;
            repeat (30) @(posedge clk);
            check_eq("no_done_after_abort", 32'(n_done), 32'(d0));
            check_eq("idle_after_abort", 32'(busy), 32'd0);
        end else begin
            k = 0;
            while (n_done == d0 && k < 3000) begin
                @(posedge clk);
                k++;
                if (poke && k == 3) begin
                    #1;
                    start  = 1'b1;
                    length = 8'd2;
                    msg    = ~m;
                end
                if (poke && k == 4) begin
                    #1 start = 1'b0;
                end
            end
            check_eq("done_seen", 32'(n_done != d0), 32'd1);
            tog_ready  = 1'b0;
            char_ready = 1'b1;
            check_eq("all_chars_fed", 32'(q_char.size()), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check_eq("result_hold", 32'(result), 32'(exp_r));
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("single_done", 32'(n_done), 32'(d0 + 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        msg        = '0;
        length     = '0;
        char_ready = 1'b1;
        thr_done   = 1'b0;
        cmp_done   = 1'b0;
        cmp_dist   = '0;
        #12;
        check_eq("reset_outs", 32'({busy, done, char_valid, ngram_valid, acc_clear,
                                    thr_start, cmp_start, cmp_class, result}), 32'd0);
        check_eq("reset_char", 32'(char_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_msg(5,   100, 300, 1'b0, 1'b0, 1'b0, 0);  // ham, latency 14
        run_msg(10,  412, 97,  1'b1, 1'b0, 1'b0, 0);  // spam, ready toggling
        run_msg(7,   256, 256, 1'b0, 1'b0, 1'b0, 0);  // tie
        run_msg(2,   10,  20,  1'b0, 1'b0, 1'b0, 0);  // early exit
        run_msg(0,   10,  20,  1'b0, 1'b0, 1'b0, 0);  // empty message
        run_msg(3,   1,   0,   1'b0, 1'b0, 1'b0, 0);  // exactly NGRAM chars
        run_msg(250, 50,  60,  1'b0, 1'b0, 1'b0, 0);  // clamps to 200
        run_msg(5,   10,  20,  1'b0, 1'b1, 1'b0, 0);  // spam compare hangs
        run_msg(20,  10,  20,  1'b0, 1'b0, 1'b0, 6);  // reset mid-FEED
        run_msg(12,  700, 699, 1'b0, 1'b0, 1'b1, 0);  // start while busy
        run_msg(4,   0,   1023, 1'b1, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hdc_classify_seq
`default_nettype wire

// File: doc/hdc_classify_seq.md
Name: hdc_classify_seq

Overview:
- Control sequencer for the hyperdimensional spam/ham classifier datapath.
- Accepts one message (up to MESSAGE_LENGTH chars plus length) per start.
- Streams characters one per handshake into the n-gram encoder/bundler, triggers bundle thresholding, then triggers Hamming comparison against the ham and spam class hypervectors.
- Returns a 2-bit label, with inconclusive and error codes. Sits between the message source and the encoder/associative-memory datapath.

Parameters:
- MESSAGE_LENGTH, 200, max chars per message.
- CHAR_LENGTH, 8, bits per char.
- NGRAM, 3, n-gram size; a bundle contribution is valid only once NGRAM chars have been fed.
- DIM, 1024, hypervector dimension.
- DIST_W, $clog2(DIM)+1, width of the Hamming distance.
- TIMEOUT, 4096, max wait cycles for thr_done/cmp_done; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin classification; sampled only in IDLE.
- msg  in  CHAR_LENGTH*MESSAGE_LENGTH  message; char 0 = msg[CHAR_LENGTH*MESSAGE_LENGTH-1 -: CHAR_LENGTH].
- length  in  8  char count.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  2  00 ham, 01 spam, 10 error/timeout, 11 inconclusive.
- char_out  out  CHAR_LENGTH  current char to encoder.
- char_valid  out  1  char_out valid.
- char_ready  in  1  encoder accepts char.
- ngram_valid  out  1  qualifies the current char as completing a full n-gram.
- acc_clear  out  1  one-cycle pulse clearing the bundle accumulator/shift window.
- thr_start  out  1  one-cycle pulse to threshold the bundle.
- thr_done  in  1  threshold complete.
- cmp_start  out  1  one-cycle pulse to start a distance computation.
- cmp_class  out  1  0 ham, 1 spam; stable from cmp_start until cmp_done.
- cmp_done  in  1  distance ready.
- cmp_dist  in  DIST_W  distance, sampled when cmp_done is high.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All outputs 0, including result=00.
  - Internal index, distances and timer cleared.
  - Reset mid-operation aborts immediately; no done pulse.
- IDLE: on start=1, latch msg and len_eff = min(length, MESSAGE_LENGTH). Go to CLEAR. start while busy is ignored.
- CLEAR (1 cycle): acc_clear=1, idx=0.
  - If len_eff < NGRAM: go to DONE with result 11; no chars are fed.
  - Otherwise go to FEED.
- FEED:
  - char_valid=1, char_out = char[idx].
  - ngram_valid = (idx >= NGRAM-1).
  - A transfer occurs when char_valid & char_ready; idx increments on each transfer.
  - The transfer with idx = len_eff-1 moves to THRESH.
  - char_valid deasserts in the cycle after the last transfer.
- THRESH:
  - thr_start=1 in the first cycle only.
  - Wait for thr_done; thr_done in the pulse cycle is ignored.
  - Then go to CMP with class 0.
- CMP (class c):
  - cmp_start=1 in the first cycle; cmp_class=c.
  - On cmp_done, capture cmp_dist into d_ham (c=0) or d_spam (c=1).
  - After class 0, re-enter for class 1; after class 1, go to DECIDE.
- Watchdog:
  - Timer resets on entry to THRESH and each CMP, and counts while waiting.
  - Reaching TIMEOUT goes to DONE with result 10.
- DECIDE (1 cycle):
  - result = 00 if d_ham < d_spam.
  - result = 01 if d_spam < d_ham.
  - result = 11 if equal (unsigned compare).
- DONE (1 cycle): done=1, then IDLE.
- result is registered and held from the done cycle until the next accepted start's CLEAR, where it clears to 00.
- busy=1 in all states except IDLE.
- Latency, with char_ready tied 1 and each *_done arriving the cycle after its start pulse (L = len_eff ≥ NGRAM): done is high L+9 cycles after the start-sampling edge.
- Early exit: len_eff < NGRAM gives done 2 cycles after start.

Decomposition:
- Shared package hdc_pkg:
  - Label constants LABEL_HAM=2'b00, LABEL_SPAM=2'b01, LABEL_ERR=2'b10, LABEL_INCONCL=2'b11.
  - State encoding.
  - CHAR_LENGTH and MESSAGE_LENGTH defaults.
- Sub-module hdc_wait_timer: load/count/expire watchdog, parameterised by TIMEOUT, with 0 meaning never expire.

Test Plan:
- Length 5, NGRAM=3, ready=1, distances ham=100, spam=300 → chars 0..4 streamed on consecutive cycles; ngram_valid high for idx 2..4; result 00; done at cycle 14.
- Length 10, ham=412, spam=97, char_ready toggling 1/0 → exactly 10 transfers in order, no char repeated or dropped; result 01.
- Equal distances 256/256 → result 11. Length 2 → no char_valid, done at cycle 2, result 11.
- Length 250 → len_eff clamps to 200, exactly 200 transfers, last char = msg[7:0].
- TIMEOUT=16, cmp_done never asserted for class 1 → done 16 wait cycles after cmp_start, result 10.
- reset=0 pulsed mid-FEED → all outputs 0 asynchronously, no done; a new start then runs a full classification correctly; start asserted while busy is ignored.
